// File: rtl/step_scheduler.sv
// Step sequencer transport/pattern controller: restarts the BPM counter,
// walks a programmable-length step index on each Tick and fires fixed-length
// per-track gate pulses from a register-held pattern.
// Ports:
//   Clock/Reset           : clock, synchronous active-high reset
//   Play/Stop             : one-cycle transport pulses (Stop wins over Play)
//   Tick                  : beat pulse from the BPM counter
//   Length                : active steps (0 or > NUM_STEPS selects NUM_STEPS)
//   WrEn/WrTrack/WrStep/WrData : pattern bit write port
//   BpmStart_n            : active-low one-cycle restart pulse to the BPM counter
//   StepIdx/Gate/Running  : current step, per-track gates, transport active
module step_scheduler #(
  parameter int NUM_TRACKS  = 4,
  parameter int NUM_STEPS   = 16,
  parameter int GATE_CYCLES = 5_000_000,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
  localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Play,
  input  logic                  Stop,
  input  logic                  Tick,
  input  logic [SW:0]           Length,
  input  logic                  WrEn,
  input  logic [TW-1:0]         WrTrack,
  input  logic [SW-1:0]         WrStep,
  input  logic                  WrData,
  output logic                  BpmStart_n,
  output logic [SW-1:0]         StepIdx,
  output logic [NUM_TRACKS-1:0] Gate,
  output logic                  Running
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           step_q, step_d;
  logic [NUM_TRACKS-1:0]   gate_q, fire_bits;
  logic [CW-1:0]           cnt_q;
  logic                    bpm_n_q, running_q;
  logic                    fire, clear, restart;
  logic [SW:0]             len_eff;
  logic                    last;
  logic                    wr_ok;
  logic [NUM_STEPS-1:0]    pat [NUM_TRACKS];

  assign len_eff = (Length == '0 || Length > (SW+1)'(NUM_STEPS))
                 ? (SW+1)'(NUM_STEPS) : Length;
  // Also true when Length shrank below the current index: wrap next Tick.
  assign last = {1'b0, step_q} >= (len_eff - (SW+1)'(1));

  assign wr_ok = WrEn
              && (32'(WrTrack) < 32'(NUM_TRACKS))
              && (32'(WrStep) < 32'(NUM_STEPS));

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fire    = 1'b0;
    clear   = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear  = 1'b1;
        step_d = '0;
        if (!Stop && Play) begin
          state_d = ARM;
          restart = 1'b1;
        end
      end
      ARM: begin
        if (Stop) begin
          state_d = IDLE;
          clear   = 1'b1;
          step_d  = '0;
        end else if (Play) begin
          restart = 1'b1;
          clear   = 1'b1;
          step_d  = '0;
        end else if (Tick) begin
          state_d = RUN;
          step_d  = '0;
          fire    = 1'b1;
        end
      end
      RUN: begin
        if (Stop) begin
          state_d = IDLE;
          clear   = 1'b1;
          step_d  = '0;
        end else if (Play) begin
          state_d = ARM;
          restart = 1'b1;
          clear   = 1'b1;
          step_d  = '0;
        end else if (Tick) begin
          step_d = last ? '0 : step_q + SW'(1);
          fire   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
        step_d  = '0;
      end
    endcase
  end

  // Reads the pattern as it stands this cycle, so a same-cycle write
  // to the fired step only shows on the next visit.
  always_comb begin
    fire_bits = '0;
    for (int t = 0; t < NUM_TRACKS; t++)
      fire_bits[t] = pat[t][step_d];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q    <= '0;
      gate_q    <= '0;
      cnt_q     <= '0;
      bpm_n_q   <= 1'b1;
      running_q <= 1'b0;
      for (int t = 0; t < NUM_TRACKS; t++)
        pat[t] <= '0;
    end else begin
      step_q    <= step_d;
      bpm_n_q   <= ~restart;
      running_q <= (state_d != IDLE);
      if (clear) begin
        gate_q <= '0;
        cnt_q  <= '0;
      end else if (fire) begin
        gate_q <= fire_bits;
        cnt_q  <= CW'(GATE_CYCLES - 1);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        gate_q <= '0;
      end
      if (wr_ok)
        pat[WrTrack][WrStep] <= WrData;
    end
  end

  assign BpmStart_n = bpm_n_q;
  assign StepIdx    = step_q;
  assign Gate       = gate_q;
  assign Running    = running_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler: two instances (gate length 4 and 8)
// share stimulus; expected values are hand-computed per vector.
module tb_step_scheduler;

  logic       clk = 1'b0;
  logic       rst, play, stop, tick;
  logic [4:0] length;
  logic       wr_en, wr_data;
  logic [1:0] wr_track;
  logic [3:0] wr_step;

  logic       bpm4_n, run4, bpm8_n, run8;
  logic [3:0] step4, gate4, step8, gate8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  step_scheduler #(.NUM_TRACKS(4), .NUM_STEPS(16), .GATE_CYCLES(4)) dut4 (
    .Clock(clk), .Reset(rst), .Play(play), .Stop(stop), .Tick(tick),
    .Length(length), .WrEn(wr_en), .WrTrack(wr_track), .WrStep(wr_step),
    .WrData(wr_data), .BpmStart_n(bpm4_n), .StepIdx(step4), .Gate(gate4),
    .Running(run4)
  );

  step_scheduler #(.NUM_TRACKS(4), .NUM_STEPS(16), .GATE_CYCLES(8)) dut8 (
    .Clock(clk), .Reset(rst), .Play(play), .Stop(stop), .Tick(tick),
    .Length(length), .WrEn(wr_en), .WrTrack(wr_track), .WrStep(wr_step),
    .WrData(wr_data), .BpmStart_n(bpm8_n), .StepIdx(step8), .Gate(gate8),
    .Running(run8)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int t, input int s, input logic d);
    wr_en    = 1'b1;
    wr_track = 2'(t);
    wr_step  = 4'(s);
    wr_data  = d;
    cyc();
    wr_en    = 1'b0;
  endtask

  task automatic chk_reset4(input string tag);
    check({tag, "_step"}, 32'(step4), 0);
    check({tag, "_gate"}, 32'(gate4), 0);
    check({tag, "_run"},  32'(run4),  0);
    check({tag, "_bpm"},  32'(bpm4_n), 1);
  endtask

  initial begin
    logic [3:0] t0_bits;
    logic [3:0] eg;
    rst = 1'b1; play = 1'b0; stop = 1'b0; tick = 1'b0;
    length = 5'd0; wr_en = 1'b0; wr_data = 1'b0;
    wr_track = '0; wr_step = '0;
    cyc();
    rst = 1'b0;
    chk_reset4("rst");
    check("rst8_bpm", 32'(bpm8_n), 1);

    // Gate length 4, tick every 10 clocks, track0 steps 0 and 2.
    wr(0, 0, 1'b1);
    wr(0, 2, 1'b1);
    length = 5'd4;
    play = 1'b1;
    cyc();
    play = 1'b0;
    check("play_bpm_lo", 32'(bpm4_n), 0);
    check("play_run",    32'(run4),   1);
    cyc();
    check("play_bpm_hi", 32'(bpm4_n), 1);
    t0_bits = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) begin
        tick = (i == 0);
        cyc();
        tick = 1'b0;
        check($sformatf("a_step%0d_%0d", k, i), 32'(step4), k % 4);
        eg = {3'b000, t0_bits[k % 4] && (i < 4)};
        check($sformatf("a_gate%0d_%0d", k, i), 32'(gate4), 32'(eg));
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_run",  32'(run4),  0);
    check("stop_step", 32'(step4), 0);
    check("stop_gate", 32'(gate4), 0);

    // Length 3 with continuous ticks, then full length.
    length = 5'd3;
    play = 1'b1;
    cyc();
    play = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("len3_%0d", i), 32'(step4), i % 3);
    end
    length = 5'd0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      check($sformatf("len16_%0d", i), 32'(step4), (i + 3) % 16);
    end
    tick = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Gate length 8, tick every 5 clocks, track1 steps 0-3: continuous high.
    for (int s = 0; s < 4; s++) wr(1, s, 1'b1);
    play = 1'b1;
    cyc();
    play = 1'b0;
    cyc();
    for (int i = 0; i < 28; i++) begin
      tick = (i % 5 == 0) && (i <= 15);
      cyc();
      tick = 1'b0;
      check($sformatf("c_gate1_%0d", i), 32'(gate8[1]), 32'(i <= 22));
    end
    check("c_step", 32'(step8), 3);

    // Shorten to 4: step 3 wraps to 0; then Play+Tick suppresses the fire.
    length = 5'd4;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("wrap_step", 32'(step8), 0);
    check("wrap_gate", 32'(gate8), 32'h3);
    play = 1'b1; tick = 1'b1;
    cyc();
    play = 1'b0; tick = 1'b0;
    check("pt_step", 32'(step8), 0);
    check("pt_gate", 32'(gate8), 0);
    check("pt_bpm",  32'(bpm8_n), 0);
    check("pt_run",  32'(run8), 1);
    stop = 1'b1; play = 1'b1;
    cyc();
    stop = 1'b0; play = 1'b0;
    check("sp_run", 32'(run8), 0);
    check("sp_bpm", 32'(bpm8_n), 1);
    check("sp_step", 32'(step8), 0);

    // Read-before-write on the step being fired.
    play = 1'b1;
    cyc();
    play = 1'b0;
    tick = 1'b1;
    cyc();
    check("rbw_s0", 32'(gate4), 32'h3);
    wr(2, 1, 1'b1);
    check("rbw_s1_step", 32'(step4), 1);
    check("rbw_s1_old",  32'(gate4), 32'h2);
    cyc();
    check("rbw_s2", 32'(gate4), 32'h3);
    cyc();
    check("rbw_s3", 32'(gate4), 32'h2);
    cyc();
    check("rbw_s0b", 32'(gate4), 32'h3);
    cyc();
    check("rbw_s1_new", 32'(gate4), 32'h6);
    tick = 1'b0;

    // All gates high, then reset mid-run clears pattern and outputs.
    for (int t = 0; t < 4; t++) wr(t, 2, 1'b1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("all_step", 32'(step4), 2);
    check("all_gate", 32'(gate4), 32'hf);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset4("midrst");
    play = 1'b1;
    cyc();
    play = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("clr_gate", 32'(gate4), 0);
    check("clr_step", 32'(step4), 0);
    check("clr_run",  32'(run4), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
# step_scheduler

Transport and pattern controller for the step sequencer. It starts and restarts the BPM counter and consumes that counter's per-beat `Step` pulse as its `Tick`. It walks a programmable-length step index and fires fixed-length gate pulses on each track whose pattern bit is set at the current step. It sits between the user-input/edit logic and the per-track sound/LED outputs.

## Interface
- `NUM_TRACKS`, 4, number of tracks (gate outputs, pattern rows)
- `NUM_STEPS`, 16, steps per pattern row; index width `SW = clog2(NUM_STEPS)` (4)
- `GATE_CYCLES`, 5_000_000, gate high time in clocks (100 ms at 50 MHz); must be ≥ 1
- `Clock  in  1  system clock (50 MHz)`
- `Reset  in  1  synchronous, active-high reset`
- `Play  in  1  one-cycle pulse: start, or restart from step 0`
- `Stop  in  1  one-cycle pulse: stop transport`
- `Tick  in  1  beat pulse from BPM counter Step output`
- `Length  in  SW+1  active steps; 0 or >NUM_STEPS means NUM_STEPS`
- `WrEn  in  1  pattern write strobe`
- `WrTrack  in  clog2(NUM_TRACKS)  write row`
- `WrStep  in  SW  write column`
- `WrData  in  1  bit to write`
- `BpmStart_n  out  1  active-low one-cycle restart pulse to BPM counter nStart`
- `StepIdx  out  SW  current step index`
- `Gate  out  NUM_TRACKS  per-track gate, high GATE_CYCLES clocks per fire`
- `Running  out  1  high in ARM and RUN`

## Operation
- Pattern: NUM_TRACKS×NUM_STEPS bit array in registers, cleared by Reset. Written in any state when `WrEn`; out-of-range WrTrack/WrStep ignored.
- Effective length L = (Length==0 || Length>NUM_STEPS) ? NUM_STEPS : Length.
- FSM states:
  - IDLE: Gate=0, StepIdx=0. `Play` → ARM and assert BpmStart_n=0 for that one registered cycle. `Tick` ignored.
  - ARM: wait for first `Tick`. On Tick: fire step 0 → RUN. `Stop` → IDLE.
  - RUN: on `Tick`, next = (StepIdx ≥ L−1) ? 0 : StepIdx+1, then fire step next. `Play` → ARM, StepIdx=0, Gate=0, BpmStart_n pulse. `Stop` → IDLE.
- Priority in a single cycle: Reset > Stop > Play > Tick. Play or Stop in the same cycle as Tick suppresses that fire.
- Fire step s: Gate[t] ← pattern[t][s] for all t, and reload the gate counter to GATE_CYCLES−1. One shared counter serves all tracks. Tracks with a 0 bit drop low on fire (retrigger semantics).
- Gate counter: decrements while nonzero. The cycle it reaches 0 with no new fire, Gate ← 0. A fire while the counter is running reloads it, so consecutive set steps with tick period ≤ GATE_CYCLES give a continuous high.
- Read-before-write: if a write hits the step being fired in the same cycle, the fire uses the old bit. The new bit takes effect on the next visit.
- If Length shrinks mid-run so StepIdx ≥ L−1, the next Tick wraps to 0.

## Timing
- Reset values: StepIdx=0, Gate=0, Running=0, BpmStart_n=1, state IDLE, pattern all 0.
- All outputs are registered.
- Play at cycle n → BpmStart_n=0 during n+1 only, Running=1 from n+1.
- The BPM counter answers nStart with Step=1 one clock later. Tick therefore arrives about n+2, and Gate/StepIdx update on the clock after Tick.
- Tick at cycle n in RUN → StepIdx and Gate valid at n+1. Gate stays high for exactly GATE_CYCLES cycles (n+1 … n+GATE_CYCLES) unless refired.
- Stop at n → Gate=0, StepIdx=0, Running=0 at n+1.
- Reset mid-run → all reset values next cycle, pattern cleared.

## Test plan
- Reset with Gate=4'b1111 active and RUN state → next cycle all outputs at reset values, pattern reads 0 on the next run.
- GATE_CYCLES=4: write track0 bits at steps 0,2. Play, Tick every 10 clocks → BpmStart_n low 1 cycle. Gate[0] high 4 cycles at StepIdx 0 and 2, low at StepIdx 1 and 3.
- Length=3, ticks continuous → StepIdx 0,1,2,0,1,2. Then Length=0 → sequence runs 0..15 and wraps.
- GATE_CYCLES=8, Tick every 5 clocks, track1 bits set on steps 0–3 → Gate[1] continuously high from the step-0 fire to 8 clocks after the step-3 fire.
- Play and Tick in the same cycle during RUN → no fire, StepIdx=0, Gate=0, BpmStart_n pulse. Stop+Play in the same cycle → IDLE, Running=0.
- Write WrData=1 to the current next step in the Tick cycle → that fire's Gate bit=0. Next visit to the step → Gate bit=1.
